biriscv_fetch_mo: RTL

Multi-outstanding instruction fetch unit. It is the parametrised successor to the single-request fetch stage and sits between the branch predictor / next-PC logic and the icache, feeding decode.
- Up to OUTSTANDING icache reads may be in flight at once.
- Responses are buffered in a FIFO_DEPTH-entry response queue, replacing the single skid register.
- Fetch width is configurable.
- On redirect, in-flight responses are killed by a counter, with no icache abort.

---
 rtl/biriscv_defs.sv | 29 ++
 rtl/biriscv_fetch_fifo.sv | 69 ++++++
 rtl/biriscv_fetch_mo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/biriscv_defs.sv
// Shared definitions for the multi-outstanding fetch unit: privilege levels
// and bit offsets of the response-queue entry {page_fault, error, pred, pc, inst}.
package biriscv_defs;

  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPER   = 2'd1;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  function automatic int unsigned resp_pc_lsb(input int unsigned fetch_w);
    return fetch_w;
  endfunction

  function automatic int unsigned resp_pred_lsb(input int unsigned fetch_w);
    return fetch_w + 32;
  endfunction

  function automatic int unsigned resp_err_bit(input int unsigned fetch_w);
    return fetch_w + 32 + (fetch_w / 32);
  endfunction

  function automatic int unsigned resp_pf_bit(input int unsigned fetch_w);
    return fetch_w + 33 + (fetch_w / 32);
  endfunction

  function automatic int unsigned resp_w(input int unsigned fetch_w);
    return fetch_w + 34 + (fetch_w / 32);
  endfunction

endpackage

// File: rtl/biriscv_fetch_fifo.sv
// Generic synchronous FIFO with occupancy count, synchronous clear and
// first-word-fall-through head; head reads as zero while empty.
module biriscv_fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A pop frees the slot the push lands in, so push+pop is legal even when full.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !i_clr) begin
      assert (!(i_push && w_full && !w_pop))
        else $error("biriscv_fetch_fifo: push into full queue");
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/biriscv_fetch_mo.sv
// Multi-outstanding instruction fetch: issues up to OUTSTANDING icache reads,
// buffers responses in a queue, and kills stale responses after a redirect.
module biriscv_fetch_mo
  import biriscv_defs::*;
#(
  parameter int unsigned FETCH_W     = 64,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branch_request_i,
  input  logic [31:0]            branch_pc_i,
  input  logic [1:0]             branch_priv_i,
  input  logic [31:0]            next_pc_f_i,
  input  logic [FETCH_W/32-1:0]  next_taken_f_i,
  input  logic                   jtag_halt_hart_i,
  input  logic                   fetch_invalidate_i,
  input  logic                   icache_accept_i,
  input  logic                   icache_valid_i,
  input  logic                   icache_error_i,
  input  logic                   icache_page_fault_i,
  input  logic [FETCH_W-1:0]     icache_inst_i,
  output logic                   icache_rd_o,
  output logic [31:0]            icache_pc_o,
  output logic [1:0]             icache_priv_o,
  output logic                   icache_flush_o,
  output logic                   icache_invalidate_o,
  input  logic                   fetch_accept_i,
  output logic                   fetch_valid_o,
  output logic [FETCH_W-1:0]     fetch_instr_o,
  output logic [31:0]            fetch_pc_o,
  output logic [FETCH_W/32-1:0]  fetch_pred_branch_o,
  output logic                   fetch_fault_fetch_o,
  output logic                   fetch_fault_page_o,
  output logic [31:0]            pc_f_o,
  output logic                   pc_accept_o
);

  localparam int unsigned NS      = FETCH_W / 32;
  localparam int unsigned AW      = $clog2(FETCH_W / 8);
  localparam int unsigned IW      = $clog2(OUTSTANDING + 1);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW      = 32 + NS;
  localparam int unsigned RW      = resp_w(FETCH_W);
  localparam int unsigned PC_LSB  = resp_pc_lsb(FETCH_W);
  localparam int unsigned PRD_LSB = resp_pred_lsb(FETCH_W);
  localparam int unsigned ERR_BIT = resp_err_bit(FETCH_W);
  localparam int unsigned PF_BIT  = resp_pf_bit(FETCH_W);

  logic            r_active;
  logic [31:0]     r_pc_f;
  logic [1:0]      r_priv;
  logic [IW-1:0]   r_inflight;
  logic [IW-1:0]   r_kill_cnt;
  logic            r_flush;

  logic [31:0]     w_pc_aligned;
  logic            w_issue_ok;
  logic            w_issue;
  logic            w_resp_any;
  logic            w_resp_live;
  logic [IW-1:0]   w_tag_cnt;
  logic [TW-1:0]   w_tag_head;
  logic [CW-1:0]   w_resp_cnt;
  logic [RW-1:0]   w_resp_in;
  logic [RW-1:0]   w_resp_head;

  assign w_pc_aligned = {r_pc_f[31:AW], AW'(0)};

  // Credit rule: every in-flight read must already own a response-queue slot.
  assign w_issue_ok = r_active & ~jtag_halt_hart_i & ~branch_request_i
                    & (32'(r_inflight) < OUTSTANDING)
                    & ((32'(r_inflight) + 32'(w_resp_cnt)) < FIFO_DEPTH);
  assign w_issue    = w_issue_ok & icache_accept_i;
  assign w_resp_any = icache_valid_i & (r_inflight != '0);
  assign w_resp_live = w_resp_any & (r_kill_cnt == '0) & ~branch_request_i
                     & (w_tag_cnt != '0);

  assign w_resp_in = {icache_page_fault_i, icache_error_i,
                      w_tag_head[NS-1:0], w_tag_head[TW-1:NS], icache_inst_i};

  biriscv_fetch_fifo #(.WIDTH(TW), .DEPTH(OUTSTANDING)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (branch_request_i),
    .i_push  (w_issue),
    .i_data  ({w_pc_aligned, next_taken_f_i}),
    .i_pop   (w_resp_live),
    .o_data  (w_tag_head),
    .o_count (w_tag_cnt)
  );

  biriscv_fetch_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_resp_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (branch_request_i),
    .i_push  (w_resp_live),
    .i_data  (w_resp_in),
    .i_pop   (fetch_accept_i),
    .o_data  (w_resp_head),
    .o_count (w_resp_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_pc_f     <= '0;
      r_priv     <= PRIV_MACHINE;
      r_inflight <= '0;
      r_kill_cnt <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= fetch_invalidate_i;
      if (branch_request_i) begin
        // Everything still outstanding belongs to the old stream.
        r_active   <= 1'b1;
        r_pc_f     <= branch_pc_i;
        r_priv     <= branch_priv_i;
        r_inflight <= r_inflight - IW'(w_resp_any);
        r_kill_cnt <= r_inflight - IW'(w_resp_any);
      end else begin
        if (w_issue) r_pc_f <= next_pc_f_i;
        r_inflight <= r_inflight + IW'(w_issue) - IW'(w_resp_any);
        if (w_resp_any && (r_kill_cnt != '0)) r_kill_cnt <= r_kill_cnt - IW'(1);
      end
    end
  end

  assign icache_rd_o         = w_issue_ok;
  assign icache_pc_o         = w_pc_aligned;
  assign icache_priv_o       = r_priv;
  assign icache_flush_o      = r_flush;
  assign icache_invalidate_o = 1'b0;
  assign pc_f_o              = r_pc_f;
  assign pc_accept_o         = w_issue;

  assign fetch_valid_o       = (w_resp_cnt != '0);
  assign fetch_instr_o       = w_resp_head[FETCH_W-1:0];
  assign fetch_pc_o          = w_resp_head[PC_LSB +: 32];
  assign fetch_pred_branch_o = w_resp_head[PRD_LSB +: NS];
  assign fetch_fault_fetch_o = w_resp_head[ERR_BIT];
  assign fetch_fault_page_o  = w_resp_head[PF_BIT];

endmodule
